// File: rtl/sign_sub_sequencer.sv
// sign_sub_sequencer: nibble-serial signed subtractor with start/busy/done handshake; define SAT_RESULT_EN to saturate result on overflow
module full_subtractor4 (
  input  logic       rst,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  logic [4:0] t;
  assign t    = {1'b0, x} - {1'b0, y} - {4'b0, bin};
  assign d    = rst ? t[3:0] : 4'h0;
  assign bout = rst & t[4];
endmodule

module sign_sub_sequencer #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         neg,
  output logic         ovf,
  output logic         zero,
  output logic         borrow
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] sa, sb, r_wrap, r_fin;
  logic [3:0] d;
  logic [2:0] cnt;
  logic bout, br, last, ovf_n, neg_n;
  full_subtractor4 u_sub (.rst(1'b1), .x(sa[3:0]), .y(sb[3:0]), .bin(br), .d(d), .bout(bout));
  assign last   = cnt == 3'(NIBBLES - 1);
  assign r_wrap = W'({d, result} >> 4);
  assign ovf_n  = (sa[3] != sb[3]) && (d[3] != sa[3]);
  assign neg_n  = d[3] ^ ovf_n;
`ifdef SAT_RESULT_EN
  assign r_fin  = ovf_n ? (neg_n ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : r_wrap;
`else
  assign r_fin  = r_wrap;
`endif
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next-state: one RUN cycle per nibble, single DONE cycle
  always_comb
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  // handshake outputs decoded from state
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  // operand shift, borrow chain, result assembly and flags on the last nibble
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sa <= '0; sb <= '0; br <= 1'b0; cnt <= '0; result <= '0;
      neg <= 1'b0; ovf <= 1'b0; zero <= 1'b0; borrow <= 1'b0;
    end else if (state == IDLE && start) begin
      sa <= a; sb <= b; br <= 1'b0; cnt <= '0; result <= '0;
      neg <= 1'b0; ovf <= 1'b0; zero <= 1'b0; borrow <= 1'b0;
    end else if (state == RUN) begin
      sa <= sa >> 4;
      sb <= sb >> 4;
      br <= bout;
      cnt <= cnt + 3'd1;
      result <= last ? r_fin : r_wrap;
      if (last) begin
        neg <= neg_n;
        ovf <= ovf_n;
        zero <= r_fin == '0;
        borrow <= bout;
      end
    end
endmodule

// File: tb/tb_sign_sub_sequencer.sv
// tb_sign_sub_sequencer: randomized scoreboard bench for sign_sub_sequencer against an integer-arithmetic model
module tb_sign_sub_sequencer;
  localparam int NIB = 4;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [15:0] a = '0, b = '0, result;
  logic busy, done, neg, ovf, zero, borrow;
  int checks = 0, failures = 0, cyc = 0;
  logic prev_done = 1'b0;
  typedef struct {logic [15:0] r; logic n, o, z, br; int t;} exp_t;
  exp_t sbq[$];

  sign_sub_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .neg(neg), .ovf(ovf), .zero(zero), .borrow(borrow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input int t);
    exp_t e;
    int dv;
    dv = int'($signed(x)) - int'($signed(y));
    e.o = dv > 32767 || dv < -32768;
    e.n = dv < 0;
    e.br = x < y;
    e.r = 16'(dv);
`ifdef SAT_RESULT_EN
    if (e.o) e.r = e.n ? 16'h8000 : 16'h7fff;
`endif
    e.z = e.r == 16'h0;
    e.t = t;
    return e;
  endfunction

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      chk("done_expected", sbq.size() != 0, 1);
      chk("done_width", prev_done, 0);
      chk("busy_at_done", busy, 0);
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_cycle", cyc, e.t);
        chk("result", result, e.r);
        chk("neg", neg, e.n);
        chk("ovf", ovf, e.o);
        chk("zero", zero, e.z);
        chk("borrow", borrow, e.br);
      end
    end
    prev_done = done;
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    a = x; b = y; start = 1'b1;
    sbq.push_back(model(x, y, cyc + 1 + NIB));
  endtask

  task automatic op(input logic [15:0] x, input logic [15:0] y);
    issue(x, y);
    @(negedge clk); start = 1'b0;
    chk("busy_after_accept", busy, 1);
    repeat (5) @(negedge clk);
    chk("idle_after_done", {busy, done}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, result, neg, ovf, zero, borrow}, 0);
    rst = 1'b1;
    @(negedge clk);
    op(16'h0005, 16'h0003);
    op(16'h0003, 16'h0005);
    op(16'h7fff, 16'hffff);
    op(16'h8000, 16'h0001);
    // start pulsed again during RUN must not launch a second operation
    issue(16'h1234, 16'h1234);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_during_run", busy, 1);
    repeat (3) @(negedge clk);
    chk("idle_after_ignored_start", {busy, done}, 0);
    // async reset on the second RUN cycle aborts without a done pulse
    a = 16'h0005; b = 16'h0003; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1 chk("abort_outputs", {busy, done, result, neg, ovf, zero, borrow}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    op(16'h0010, 16'h0001);
    // start held high: back-to-back operations
    for (int i = 0; i < 3; i++) begin
      issue(16'($urandom), 16'($urandom));
      repeat (6) @(negedge clk);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      logic [15:0] x, y;
      x = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
      y = ($urandom_range(0, 4) == 0) ? x : 16'($urandom);
      op(x, y);
    end
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    chk("queue_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
